// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its fetch and load/store requesters,
// and the single-port memory (combinational read, write on the clock edge).
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ack;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_ack;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_data_out;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
      output i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_data_in, mem_we
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_data_in, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter serialising accesses to one memory via IDLE/ACCESS/RESP.
// Optional grant/conflict counters are compiled in with `define MEM_ARB_STATS_EN.
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]  stat_i_grants,
   output logic [31:0]  stat_d_grants,
   output logic [31:0]  stat_conflicts
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic                  i_ack_q, i_ack_d;
   logic                  d_ack_q, d_ack_d;
   logic                  tie_pick;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         rdata_q      <= '0;
         grant_q      <= GNT_D;
         last_grant_q <= GNT_D;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         rdata_q      <= rdata_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      rdata_d      = rdata_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      // On a tie, round-robin hands the grant to whichever port did not win last time.
      tie_pick     = FIXED_PRIORITY ? GNT_D : ~last_grant_q;
      case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               grant_d      = bus.d_req && (!bus.i_req || tie_pick);
               last_grant_d = grant_d;
               state_d      = ACCESS;
               if (grant_d == GNT_D) begin
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
                  we_d    = bus.d_we;
               end else begin
                  addr_d  = bus.i_addr;
                  wdata_d = '0;
                  we_d    = 1'b0;
               end
            end
         end
         ACCESS: begin
            rdata_d = bus.mem_data_out;
            state_d = RESP;
         end
         RESP: begin
            i_ack_d = (grant_q == GNT_I);
            d_ack_d = (grant_q == GNT_D);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_address = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.mem_we      = (state_q == ACCESS) && we_q && !reset;
   assign bus.i_ack       = i_ack_q;
   assign bus.d_ack       = d_ack_q;
   assign bus.i_rdata     = rdata_q;
   assign bus.d_rdata     = rdata_q;

`ifdef MEM_ARB_STATS_EN
   logic        grant_fire;
   logic [31:0] stat_i_q, stat_d_q, stat_c_q;

   assign grant_fire = (state_q == IDLE) && (bus.i_req || bus.d_req);

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_i_q <= '0;
         stat_d_q <= '0;
         stat_c_q <= '0;
      end else begin
         if (grant_fire && grant_d == GNT_I) stat_i_q <= stat_i_q + 32'd1;
         if (grant_fire && grant_d == GNT_D) stat_d_q <= stat_d_q + 32'd1;
         if (state_q == IDLE && bus.i_req && bus.d_req) stat_c_q <= stat_c_q + 32'd1;
      end
   end

   assign stat_i_grants  = stat_i_q;
   assign stat_d_grants  = stat_d_q;
   assign stat_conflicts = stat_c_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: u0 round-robin, u1 fixed priority, each with its own memory model.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

`ifdef MEM_ARB_STATS_EN
   logic [31:0] s0_i, s0_d, s0_c, s1_i, s1_d, s1_c;
`endif

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b0)) u0 (
      .clk(clk), .reset(reset), .bus(bus0.slave)
`ifdef MEM_ARB_STATS_EN
      , .stat_i_grants(s0_i), .stat_d_grants(s0_d), .stat_conflicts(s0_c)
`endif
   );

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b1)) u1 (
      .clk(clk), .reset(reset), .bus(bus1.slave)
`ifdef MEM_ARB_STATS_EN
      , .stat_i_grants(s1_i), .stat_d_grants(s1_d), .stat_conflicts(s1_c)
`endif
   );

   // Memory models: combinational read, write at the clock edge.
   logic [31:0] mem0 [0:4095];
   logic [31:0] mem1 [0:4095];
   assign bus0.mem_data_out = mem0[bus0.mem_address[13:2]];
   assign bus1.mem_data_out = mem1[bus1.mem_address[13:2]];
   always @(posedge clk) begin
      if (bus0.mem_we) mem0[bus0.mem_address[13:2]] <= bus0.mem_data_in;
      if (bus1.mem_we) mem1[bus1.mem_address[13:2]] <= bus1.mem_data_in;
   end

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;
   exp_t sb0[$];
   exp_t sb1[$];

   int          we_cnt0 = 0;
   int          we_cnt1 = 0;
   logic [31:0] we_addr0 = '0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void check_ack(input int inst, input logic ia, input logic da,
                                     input logic [31:0] ird, input logic [31:0] drd);
      exp_t e;
      chk($sformatf("u%0d_ack_exclusive", inst), 32'(ia & da), 32'd0);
      if ((inst == 0 && sb0.size() == 0) || (inst == 1 && sb1.size() == 0)) begin
         chk($sformatf("u%0d_unexpected_ack", inst), 32'd1, 32'd0);
         return;
      end
      if (inst == 0) e = sb0.pop_front();
      else           e = sb1.pop_front();
      chk($sformatf("u%0d_ack_port_is_d", inst), 32'(da), 32'(e.is_d));
      chk($sformatf("u%0d_ack_rdata", inst), da ? drd : ird, e.data);
   endfunction

   // Monitor: compare every ack against the scoreboard, tally memory writes.
   always @(negedge clk) begin
      if (bus0.i_ack || bus0.d_ack) check_ack(0, bus0.i_ack, bus0.d_ack, bus0.i_rdata, bus0.d_rdata);
      if (bus1.i_ack || bus1.d_ack) check_ack(1, bus1.i_ack, bus1.d_ack, bus1.i_rdata, bus1.d_rdata);
      if (bus0.mem_we) begin
         we_cnt0++;
         we_addr0 = bus0.mem_address;
      end
      if (bus1.mem_we) we_cnt1++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ack_of(input int inst, input bit is_d);
      if (inst == 0) return is_d ? bus0.d_ack : bus0.i_ack;
      return is_d ? bus1.d_ack : bus1.i_ack;
   endfunction

   task automatic wait_ack(input int inst, input bit is_d, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!ack_of(inst, is_d) && n < 20);
   endtask

   task automatic idle_all();
      bus0.i_req = 1'b0; bus0.i_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
      bus0.d_addr = '0;  bus0.d_wdata = '0;
      bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      bus1.d_addr = '0;  bus1.d_wdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_all();
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time 100000 reached, required finish earlier");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int acks;
      int first;
      int last;
      int dacks;
      int we_before;
      bit saw_ack;
      bit i_done;
      bit d_done;

      for (int i = 0; i < 4096; i++) begin
         mem0[i] <= 32'h0;
         mem1[i] <= 32'h0;
      end
      #0;
      mem0[4] <= 32'hDEADBEEF;
      mem1[2] <= 32'h11112222;
      mem1[3] <= 32'h33334444;
      do_reset();

      // Reset state: no acks, no write.
      chk("reset_i_ack", 32'(bus0.i_ack), 32'd0);
      chk("reset_d_ack", 32'(bus0.d_ack), 32'd0);
      chk("reset_mem_we", 32'(bus0.mem_we), 32'd0);
      chk("reset_mem_address", bus0.mem_address, 32'h0);

      // Single fetch.
      sb0.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
      bus0.i_addr = 32'h10;
      bus0.i_req  = 1'b1;
      wait_ack(0, 1'b0, n);
      bus0.i_req  = 1'b0;
      chk("fetch_latency", 32'(n), 32'd3);
      chk("fetch_no_write", 32'(we_cnt0), 32'd0);

      // Store then load back; a store returns the pre-write word.
      sb0.push_back('{is_d: 1'b1, data: 32'h0});
      bus0.d_addr = 32'h20; bus0.d_wdata = 32'h12345678; bus0.d_we = 1'b1; bus0.d_req = 1'b1;
      wait_ack(0, 1'b1, n);
      bus0.d_req = 1'b0; bus0.d_we = 1'b0;
      chk("store_latency", 32'(n), 32'd3);
      chk("store_we_cycles", 32'(we_cnt0), 32'd1);
      chk("store_we_addr", we_addr0, 32'h20);
      chk("store_mem_word", mem0[8], 32'h12345678);
      sb0.push_back('{is_d: 1'b1, data: 32'h12345678});
      bus0.d_req = 1'b1;
      wait_ack(0, 1'b1, n);
      bus0.d_req = 1'b0;
      chk("load_latency", 32'(n), 32'd3);

      // Round-robin with both held from reset: I,D,I,D, 3 cycles apart.
      do_reset();
      sb0.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
      sb0.push_back('{is_d: 1'b1, data: 32'h12345678});
      sb0.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
      sb0.push_back('{is_d: 1'b1, data: 32'h12345678});
      bus0.i_addr = 32'h10; bus0.d_addr = 32'h20; bus0.d_we = 1'b0;
      bus0.i_req = 1'b1; bus0.d_req = 1'b1;
      acks = 0; first = -1; last = -1;
      for (int t = 0; t < 40 && acks < 4; t++) begin
         tick();
         if (bus0.i_ack || bus0.d_ack) begin
            acks++;
            if (first < 0) first = t;
            if (last >= 0) chk("rr_ack_spacing", 32'(t - last), 32'd3);
            last = t;
            if (acks == 4) begin
               bus0.i_req = 1'b0;
               bus0.d_req = 1'b0;
            end
         end
      end
      chk("rr_ack_count", 32'(acks), 32'd4);
      chk("rr_first_latency", 32'(first), 32'd2);
      repeat (4) tick();

      // Fixed priority: data wins every tie until it lets go.
      for (int k = 0; k < 5; k++) sb1.push_back('{is_d: 1'b1, data: 32'h11112222});
      sb1.push_back('{is_d: 1'b0, data: 32'h33334444});
      bus1.i_addr = 32'hC; bus1.d_addr = 32'h8; bus1.d_we = 1'b0;
      bus1.i_req = 1'b1; bus1.d_req = 1'b1;
      dacks = 0;
      for (int t = 0; t < 60 && dacks < 5; t++) begin
         tick();
         if (bus1.d_ack) dacks++;
      end
      bus1.d_req = 1'b0;
      chk("fp_d_ack_count", 32'(dacks), 32'd5);
      wait_ack(1, 1'b0, n);
      bus1.i_req = 1'b0;
      chk("fp_i_latency_after_drop", 32'(n), 32'd3);
      chk("fp_no_write", 32'(we_cnt1), 32'd0);
      repeat (4) tick();

      // Reset during the ACCESS cycle of a store: write and ack are lost.
      we_before = we_cnt0;
      bus0.d_addr = 32'h40; bus0.d_wdata = 32'hCAFEF00D; bus0.d_we = 1'b1; bus0.d_req = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      chk("rst_access_mem_we", 32'(bus0.mem_we), 32'd0);
      tick();
      reset = 1'b0;
      bus0.d_req = 1'b0; bus0.d_we = 1'b0;
      saw_ack = 1'b0;
      repeat (5) begin
         tick();
         if (bus0.d_ack || bus0.i_ack) saw_ack = 1'b1;
      end
      chk("rst_no_ack", 32'(saw_ack), 32'd0);
      chk("rst_word_unchanged", mem0[16], 32'h0);
      chk("rst_no_write", 32'(we_cnt0 - we_before), 32'd0);
      sb0.push_back('{is_d: 1'b1, data: 32'h0});
      bus0.d_req = 1'b1;
      wait_ack(0, 1'b1, n);
      bus0.d_req = 1'b0;
      chk("rst_then_load_latency", 32'(n), 32'd3);

      // Two simultaneous single requests from reset.
      do_reset();
      sb0.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
      sb0.push_back('{is_d: 1'b1, data: 32'h12345678});
      bus0.i_addr = 32'h10; bus0.d_addr = 32'h20; bus0.d_we = 1'b0;
      bus0.i_req = 1'b1; bus0.d_req = 1'b1;
      i_done = 1'b0; d_done = 1'b0;
      for (int t = 0; t < 30 && !(i_done && d_done); t++) begin
         tick();
         if (bus0.i_ack) begin bus0.i_req = 1'b0; i_done = 1'b1; end
         if (bus0.d_ack) begin bus0.d_req = 1'b0; d_done = 1'b1; end
      end
      chk("pair_both_done", 32'({i_done, d_done}), 32'd3);
`ifdef MEM_ARB_STATS_EN
      chk("stat_i_grants", s0_i, 32'd1);
      chk("stat_d_grants", s0_d, 32'd1);
      chk("stat_conflicts", s0_c, 32'd1);
`endif
      repeat (4) tick();

      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port unified instruction/data memory.
- The memory has a combinational read and a write on the clock edge.
- Shares the memory between the instruction-fetch port (read-only) and the load/store port (read/write).
- Serialises every access through a 3-state FSM, so at most one memory transaction is ever in flight.

Parameters:
- ADDR_WIDTH, 32, byte address width; passed through unchanged (memory indexes address[13:2]).
- DATA_WIDTH, 32, data word width.
- FIXED_PRIORITY, 0: 0 = round-robin between the two ports; 1 = load/store port always wins ties.

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held high with i_addr stable until i_ack
- i_addr  in  ADDR_WIDTH  fetch byte address
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  load/store request; held high with d_addr/d_wdata/d_we stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  load/store byte address
- d_wdata  in  DATA_WIDTH  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DATA_WIDTH  load data
- mem_address  out  ADDR_WIDTH  to memory address
- mem_data_in  out  DATA_WIDTH  to memory data_in
- mem_we  out  1  to memory we
- mem_data_out  in  DATA_WIDTH  from memory data_out (combinational)

Behaviour:
- Reset (sync, active-high) at the edge:
  - state=IDLE, i_ack=0, d_ack=0.
  - rdata_q=0, addr_q=0, wdata_q=0, we_q=0, grant_q=DATA, last_grant=DATA.
- Reset priority: round-robin favours fetch first after reset.
- Outputs:
  - mem_address=addr_q, mem_data_in=wdata_q.
  - mem_we = (state==ACCESS) & we_q & ~reset. Gating with ~reset means no write occurs at a reset edge.
  - i_rdata and d_rdata both = rdata_q; meaningful only with their ack.
- State IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: FIXED_PRIORITY=0 grants the port not in last_grant; FIXED_PRIORITY=1 grants data.
  - On grant, latch the winner's addr/wdata/we into the _q registers (fetch forces we_q=0, wdata_q=0), set grant_q and last_grant, go to ACCESS.
- State ACCESS (exactly 1 cycle):
  - Memory sees addr_q; mem_we pulses if we_q.
  - rdata_q <= mem_data_out at the edge. For a store this captures the pre-write contents.
  - Go to RESP.
- State RESP (exactly 1 cycle):
  - Assert ack of grant_q for this cycle only, then go to IDLE.
- Latency: request first sampled high at edge k in IDLE gives ack high in the cycle after edge k+2 (3 cycles req-to-ack).
- Throughput: 1 transaction per 3 cycles.
- A requester keeping req high after its ack is re-arbitrated in IDLE. With round-robin and both ports continuously requesting, grants alternate I,D,I,D.
- req dropped before the grant: withdrawn, nothing latched.
- req dropped after the grant: the transaction still completes and ack still pulses.
- Fetch never writes; i_ack and d_ack are never high together.
- Reset mid-operation (ACCESS or RESP): no write at that edge, no ack, the transaction is lost; the requester must reissue.
- Misaligned addresses are passed through unchanged; no checking.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds three 32-bit outputs, each reset to 0 and wrapping on overflow:
  - stat_i_grants: +1 per fetch grant.
  - stat_d_grants: +1 per data grant.
  - stat_conflicts: +1 per IDLE cycle with i_req & d_req both high.
- Undefined: these ports and counters do not exist; the core behaviour is identical.

Test Plan:
- Preload word 4 = 0xDEADBEEF; after reset, i_req with i_addr=0x10 -> i_ack 3 cycles later with i_rdata=0xDEADBEEF; d_ack stays 0; mem_we never 1.
- Store d_addr=0x20, d_wdata=0x12345678, d_we=1 -> mem_we high exactly 1 cycle with mem_address=0x20; d_ack follows. A subsequent load of 0x20 -> d_rdata=0x12345678.
- FIXED_PRIORITY=0, both req held from reset for 4 transactions -> ack order i,d,i,d, acks 3 cycles apart, never simultaneous.
- FIXED_PRIORITY=1, both held -> only d_ack for 5 transactions; then drop d_req -> i_ack 3 cycles later.
- Store 0xCAFEF00D to 0x40 (old value 0x0), assert reset during the ACCESS cycle -> mem_we=0, word 0x40 stays 0x0, no d_ack, state IDLE next cycle.
- With MEM_ARB_STATS_EN, 2 simultaneous i/d requests from reset -> stat_i_grants=1, stat_d_grants=1, stat_conflicts=1.
